// File: rtl/pkt_filter.sv
// Ingress classifier: steers ctrl (IPv4/UDP to CTRL_UDP_PORT) packets to the ctrl
// stream and VLAN-tagged packets to the data stream; untagged packets are dropped.
module pkt_filter #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hf2f1
) (
  input  logic                              axis_clk,
  input  logic                              areset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,

  output logic [31:0]                       data_pkt_cnt,
  output logic [31:0]                       ctrl_pkt_cnt,
  output logic [31:0]                       drop_pkt_cnt
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HOLD1 = 3'd1;
  localparam logic [2:0] S_FWD   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [DW-1:0] h_data;
  logic [UW-1:0] h_user;
  logic [KW-1:0] h_keep;
  logic          h_last;
  logic          sel, sel_nxt;     // 1 = ctrl stream, 0 = data stream

  logic in_vlan, hdr_ok, port_ok;
  logic idle_proc, h_load, emit, emit_ctrl;
  logic inc_data, inc_ctrl, inc_drop;

  assign in_vlan = s_axis_tdata[96+:16] == 16'h0081;
  assign hdr_ok  = (h_data[96+:16]  == 16'h0081) && (h_data[128+:16] == 16'h0008) &&
                   (h_data[144+:8]  == 8'h45)    && (h_data[216+:8]  == 8'h11);
  assign port_ok = s_axis_tdata[64+:16] == CTRL_UDP_PORT;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    idle_proc = 1'b0;
    h_load    = 1'b0;
    emit      = 1'b0;
    emit_ctrl = sel;
    inc_data  = 1'b0;
    inc_ctrl  = 1'b0;
    inc_drop  = 1'b0;
    case (state)
      S_IDLE: idle_proc = 1'b1;
      S_HOLD1: if (s_axis_tvalid) begin
        // Class is known only once beat 2 (UDP port) arrives; emit beat 1 on that stream.
        sel_nxt   = hdr_ok && port_ok;
        emit      = 1'b1;
        emit_ctrl = sel_nxt;
        h_load    = 1'b1;
        inc_ctrl  = sel_nxt;
        inc_data  = ~sel_nxt;
        state_nxt = s_axis_tlast ? S_FLUSH : S_FWD;
      end
      S_FWD: if (s_axis_tvalid) begin
        emit   = 1'b1;
        h_load = 1'b1;
        if (s_axis_tlast) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        emit      = 1'b1;
        state_nxt = S_IDLE;
        idle_proc = 1'b1;
      end
      S_DROP: if (s_axis_tvalid && s_axis_tlast) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // FLUSH accepts a new packet start in the same cycle, so this overrides its next state.
    if (idle_proc && s_axis_tvalid) begin
      if (!in_vlan) begin
        inc_drop  = 1'b1;
        state_nxt = s_axis_tlast ? S_IDLE : S_DROP;
      end else if (s_axis_tlast) begin
        h_load    = 1'b1;
        sel_nxt   = 1'b0;
        inc_data  = 1'b1;
        state_nxt = S_FLUSH;
      end else begin
        h_load    = 1'b1;
        state_nxt = S_HOLD1;
      end
    end
  end

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      state           <= S_IDLE;
      sel             <= 1'b0;
      h_data          <= '0;
      h_user          <= '0;
      h_keep          <= '0;
      h_last          <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tuser    <= '0;
      m_axis_tkeep    <= '0;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
      data_pkt_cnt    <= '0;
      ctrl_pkt_cnt    <= '0;
      drop_pkt_cnt    <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (h_load) begin
        h_data <= s_axis_tdata;
        h_user <= s_axis_tuser;
        h_keep <= s_axis_tkeep;
        h_last <= s_axis_tlast;
      end
      m_axis_tvalid   <= emit & ~emit_ctrl;
      c_m_axis_tvalid <= emit & emit_ctrl;
      if (emit && !emit_ctrl) begin
        m_axis_tdata <= h_data;
        m_axis_tuser <= h_user;
        m_axis_tkeep <= h_keep;
        m_axis_tlast <= h_last;
      end
      if (emit && emit_ctrl) begin
        c_m_axis_tdata <= h_data;
        c_m_axis_tuser <= h_user;
        c_m_axis_tkeep <= h_keep;
        c_m_axis_tlast <= h_last;
      end
      if (inc_data) data_pkt_cnt <= data_pkt_cnt + 32'd1;
      if (inc_ctrl) ctrl_pkt_cnt <= ctrl_pkt_cnt + 32'd1;
      if (inc_drop) drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pkt_filter.sv
// Bench for pkt_filter: a cycle schedule of input beats plus a per-cycle expectation
// table built from the packet-level rules (class from header bytes, emission latency).
module tb_pkt_filter;

  localparam int          MAXC = 1024;
  localparam logic [15:0] PORT = 16'hf2f1;
  localparam int CL_DATA = 0, CL_CTRL = 1, CL_DROP = 2;

  logic         axis_clk = 1'b0;
  logic         areset   = 1'b1;
  logic [255:0] s_axis_tdata  = '0;
  logic [127:0] s_axis_tuser  = '0;
  logic [31:0]  s_axis_tkeep  = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast  = 1'b0;
  logic [255:0] m_axis_tdata,  c_m_axis_tdata;
  logic [127:0] m_axis_tuser,  c_m_axis_tuser;
  logic [31:0]  m_axis_tkeep,  c_m_axis_tkeep;
  logic         m_axis_tvalid, c_m_axis_tvalid, m_axis_tlast, c_m_axis_tlast;
  logic [31:0]  data_pkt_cnt, ctrl_pkt_cnt, drop_pkt_cnt;

  pkt_filter #(.C_S_AXIS_DATA_WIDTH(256), .C_S_AXIS_TUSER_WIDTH(128), .CTRL_UDP_PORT(PORT)) dut (
    .axis_clk(axis_clk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser), .c_m_axis_tkeep(c_m_axis_tkeep),
    .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tlast(c_m_axis_tlast),
    .data_pkt_cnt(data_pkt_cnt), .ctrl_pkt_cnt(ctrl_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  // input schedule and expected outputs, indexed by cycle
  logic [255:0] st_data [MAXC];
  logic [127:0] st_user [MAXC];
  logic [31:0]  st_keep [MAXC];
  bit           st_vld  [MAXC];
  bit           st_last [MAXC];
  bit           ex_m    [MAXC];
  bit           ex_c    [MAXC];
  logic [416:0] ex_pay  [MAXC];
  int           inc_d [MAXC], inc_c [MAXC], inc_x [MAXC];
  int           wp;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit vlan, ipv4, ihl, udp, port;
    int nb, gap, cls;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input int c, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i+:32] = $urandom;
    return r;
  endfunction

  function automatic logic [15:0] bad16(input logic [15:0] good);
    return good ^ 16'($urandom_range(65535, 1));
  endfunction

  function automatic logic [255:0] make_b1(input bit vlan, input bit ipv4, input bit ihl, input bit udp);
    logic [255:0] d;
    logic [15:0]  t;
    d = rnd256();
    d[96+:16]  = vlan ? 16'h0081 : bad16(16'h0081);
    d[128+:16] = ipv4 ? 16'h0008 : bad16(16'h0008);
    t = bad16(16'h0045);
    d[144+:8]  = ihl ? 8'h45 : 8'h45 ^ (t[7:0] | 8'h01);
    t = bad16(16'h0011);
    d[216+:8]  = udp ? 8'h11 : 8'h11 ^ (t[7:0] | 8'h01);
    return d;
  endfunction

  function automatic logic [255:0] make_b2(input bit port);
    logic [255:0] d;
    d = rnd256();
    d[64+:16] = port ? PORT : bad16(PORT);
    return d;
  endfunction

  task automatic clear_sched();
    for (int c = 0; c < MAXC; c++) begin
      st_vld[c] = 0; st_last[c] = c[0];
      st_data[c] = {8{32'(c) * 32'h9e3779b9}};
      st_user[c] = {4{32'(c) ^ 32'h5a5a5a5a}};
      st_keep[c] = 32'(c) * 32'h01010101;
      ex_m[c] = 0; ex_c[c] = 0; ex_pay[c] = '0;
      inc_d[c] = 0; inc_c[c] = 0; inc_x[c] = 0;
    end
    wp = 0;
  endtask

  task automatic put(input int c, input logic [255:0] d, input bit last);
    st_vld[c] = 1; st_data[c] = d; st_last[c] = last;
    st_user[c] = {$urandom, $urandom, $urandom, $urandom};
    st_keep[c] = $urandom;
  endtask

  task automatic expect_beat(input int t, input bit ctrl, input int src);
    if (ctrl) ex_c[t] = 1; else ex_m[t] = 1;
    ex_pay[t] = {st_data[src], st_user[src], st_keep[src], st_last[src]};
  endtask

  // Reference model: schedules one packet and derives every expected output beat
  // and counter step straight from the classification and latency rules.
  task automatic add_pkt(input bit vlan, input bit ipv4, input bit ihl, input bit udp,
                         input bit port, input int nb, input int maxgap);
    int a[$];
    int g, cls, dec;
    logic [255:0] b1, b2;
    b1 = make_b1(vlan, ipv4, ihl, udp);
    b2 = make_b2(port);
    for (int k = 0; k < nb; k++) begin
      g = (k > 0 && $urandom_range(2, 0) == 0) ? $urandom_range(maxgap, 0) : 0;
      wp += g;
      put(wp, (k == 0) ? b1 : (k == 1) ? b2 : rnd256(), k == nb - 1);
      a.push_back(wp);
      wp++;
    end
    if (b1[96+:16] != 16'h0081) cls = CL_DROP;
    else if (nb > 1 && b1[128+:16] == 16'h0008 && b1[144+:8] == 8'h45 &&
             b1[216+:8] == 8'h11 && b2[64+:16] == PORT) cls = CL_CTRL;
    else cls = CL_DATA;
    dec = (nb == 1 || cls == CL_DROP) ? a[0] : a[1];
    case (cls)
      CL_DATA: inc_d[dec+1]++;
      CL_CTRL: inc_c[dec+1]++;
      default: inc_x[dec+1]++;
    endcase
    if (cls != CL_DROP)
      for (int k = 0; k < nb; k++)
        expect_beat((k < nb - 1) ? a[k+1] + 1 : a[k] + 2, cls == CL_CTRL, a[k]);
  endtask

  task automatic do_reset();
    s_axis_tvalid = 0;
    areset = 1;
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    areset = 0;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_ctl"}, 0, {m_axis_tvalid, c_m_axis_tvalid, m_axis_tlast, c_m_axis_tlast}, '0);
    chk({tag, "_data"}, 0, {m_axis_tdata, c_m_axis_tdata}, '0);
    chk({tag, "_user_keep"}, 0, {m_axis_tuser, c_m_axis_tuser, m_axis_tkeep, c_m_axis_tkeep}, '0);
    chk({tag, "_cnt"}, 0, {data_pkt_cnt, ctrl_pkt_cnt, drop_pkt_cnt}, '0);
  endtask

  // Drive cycles 0..n-1 of the schedule (DUT just out of reset) and check each cycle.
  task automatic run_sched(input int n);
    int ed, ec, ex;
    ed = 0; ec = 0; ex = 0;
    for (int c = 0; c < n; c++) begin
      s_axis_tvalid = st_vld[c];
      s_axis_tdata  = st_data[c];
      s_axis_tuser  = st_user[c];
      s_axis_tkeep  = st_keep[c];
      s_axis_tlast  = st_last[c];
      @(negedge axis_clk);
      ed += inc_d[c]; ec += inc_c[c]; ex += inc_x[c];
      chk("m_tvalid", c, 512'(m_axis_tvalid), 512'(ex_m[c]));
      chk("c_tvalid", c, 512'(c_m_axis_tvalid), 512'(ex_c[c]));
      if (ex_m[c] && m_axis_tvalid)
        chk("m_beat", c, 512'({m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast}), 512'(ex_pay[c]));
      if (ex_c[c] && c_m_axis_tvalid)
        chk("c_beat", c, 512'({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast}), 512'(ex_pay[c]));
      chk("data_cnt", c, 512'(data_pkt_cnt), 512'(ed));
      chk("ctrl_cnt", c, 512'(ctrl_pkt_cnt), 512'(ec));
      chk("drop_cnt", c, 512'(drop_pkt_cnt), 512'(ex));
      @(posedge axis_clk);
      #1;
    end
    s_axis_tvalid = 0;
  endtask

  initial begin
    tbl[0]  = '{1, 1, 1, 1, 1, 3, 0, CL_CTRL};
    tbl[1]  = '{1, 1, 1, 1, 1, 2, 0, CL_CTRL};
    tbl[2]  = '{1, 1, 1, 1, 1, 1, 0, CL_DATA};   // single beat can never be ctrl
    tbl[3]  = '{1, 1, 1, 1, 0, 3, 0, CL_DATA};
    tbl[4]  = '{1, 0, 1, 1, 1, 2, 0, CL_DATA};
    tbl[5]  = '{1, 1, 0, 1, 1, 2, 0, CL_DATA};
    tbl[6]  = '{1, 1, 1, 0, 1, 4, 1, CL_DATA};
    tbl[7]  = '{0, 1, 1, 1, 1, 4, 0, CL_DROP};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, CL_DROP};
    tbl[9]  = '{0, 1, 1, 1, 1, 2, 2, CL_DROP};
    tbl[10] = '{1, 1, 1, 1, 1, 5, 3, CL_CTRL};
    tbl[11] = '{1, 0, 0, 0, 0, 4, 2, CL_DATA};

    do_reset();
    zero_check("reset");

    // classification table, one packet per reset
    for (int i = 0; i < 12; i++) begin
      do_reset();
      clear_sched();
      add_pkt(tbl[i].vlan, tbl[i].ipv4, tbl[i].ihl, tbl[i].udp, tbl[i].port, tbl[i].nb, tbl[i].gap);
      run_sched(wp + 4);
      chk("tbl_data_cnt", i, 512'(data_pkt_cnt), 512'(tbl[i].cls == CL_DATA));
      chk("tbl_ctrl_cnt", i, 512'(ctrl_pkt_cnt), 512'(tbl[i].cls == CL_CTRL));
      chk("tbl_drop_cnt", i, 512'(drop_pkt_cnt), 512'(tbl[i].cls == CL_DROP));
    end

    // back-to-back: 1-beat data at 0, 2-beat ctrl at 1..2
    do_reset();
    clear_sched();
    put(0, make_b1(1, 1, 1, 1), 1);
    put(1, make_b1(1, 1, 1, 1), 0);
    put(2, make_b2(1), 1);
    expect_beat(2, 0, 0);
    expect_beat(3, 1, 1);
    expect_beat(4, 1, 2);
    inc_d[1] = 1;
    inc_c[3] = 1;
    run_sched(8);

    // gapped: beat 1 at 0, beat 2 (last) at 5
    do_reset();
    clear_sched();
    put(0, make_b1(1, 0, 1, 1), 0);
    put(5, make_b2(1), 1);
    expect_beat(6, 0, 0);
    expect_beat(7, 0, 5);
    inc_d[6] = 1;
    run_sched(10);

    // reset between beats 2 and 3 of a 4-beat data packet
    do_reset();
    clear_sched();
    put(0, make_b1(1, 1, 1, 0), 0);
    put(1, rnd256(), 0);
    inc_d[2] = 1;
    run_sched(2);
    chk("pre_rst_m_tvalid", 2, 512'(m_axis_tvalid), 512'(1));
    chk("pre_rst_m_tdata", 2, 512'(m_axis_tdata), 512'(st_data[0]));
    chk("pre_rst_data_cnt", 2, 512'(data_pkt_cnt), 512'(1));
    areset = 1;
    #1;
    zero_check("mid_rst");
    @(negedge axis_clk);
    areset = 0;
    @(posedge axis_clk);
    #1;
    clear_sched();
    add_pkt(1, 1, 1, 1, 0, 2, 0);
    run_sched(wp + 4);

    // randomized packet mix against the model
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      clear_sched();
      while (wp < MAXC - 40) begin
        add_pkt($urandom_range(4, 0) != 0, $urandom_range(4, 0) != 0, $urandom_range(4, 0) != 0,
                $urandom_range(4, 0) != 0, $urandom_range(2, 0) != 0,
                $urandom_range(5, 1), $urandom_range(3, 0));
        if ($urandom_range(1, 0) == 0) wp += $urandom_range(2, 0);
      end
      run_sched(wp + 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_filter.md
# pkt_filter

Ingress classifier that sits directly upstream of the parser and the control-path chain. It takes the 256-bit AXI-Stream from the MAC/DMA side and sorts each packet onto one of two outputs: control packets (IPv4/UDP with destination port `CTRL_UDP_PORT`) go to the ctrl stream, and VLAN-tagged data packets go to the parser/data stream. All other packets are dropped. Per-class packet counters are exported for debug.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, default 256: tdata width. The field offsets below are fixed for 256.
- `C_S_AXIS_TUSER_WIDTH`, default 128: tuser width. tuser is carried unmodified.
- `CTRL_UDP_PORT`, default 16'hf2f1: ctrl UDP destination port, given in tdata byte order (on-wire value 0xf1f2).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `axis_clk`  in  1  the single clock.
- `areset`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`, `s_axis_tuser`, `s_axis_tkeep`, `s_axis_tvalid`, `s_axis_tlast`  in  256/128/32/1/1  input stream. No tready; every valid beat is accepted.
- `m_axis_tdata`, `m_axis_tuser`, `m_axis_tkeep`, `m_axis_tvalid`, `m_axis_tlast`  out  256/128/32/1/1  data stream to the parser. All are registered.
- `c_m_axis_tdata`, `c_m_axis_tuser`, `c_m_axis_tkeep`, `c_m_axis_tvalid`, `c_m_axis_tlast`  out  256/128/32/1/1  ctrl stream. All are registered.
- `data_pkt_cnt`, `ctrl_pkt_cnt`, `drop_pkt_cnt`  out  32 each  packet counters. They wrap at 2^32.

## Operation
Byte i of a beat is `tdata[8*i+:8]`.

Field checks on beat 1:
- VLAN present: `tdata[96+:16]==16'h0081`
- IPv4: `tdata[128+:16]==16'h0008`
- IHL=5: `tdata[144+:8]==8'h45`
- UDP: `tdata[216+:8]==8'h11`

Field check on beat 2:
- Port match: `tdata[64+:16]==CTRL_UDP_PORT`

Classification:
- Ctrl: all four beat-1 checks pass and the beat-2 port matches.
- Data: VLAN present and the packet is not ctrl.
- Drop: VLAN absent.
- A 1-beat packet is never ctrl.

Storage: one holding register H of {tdata, tuser, tkeep, tlast}, one output register set per stream, and a select bit `sel` (data/ctrl).

State machine:
- IDLE:
  - On a valid beat with VLAN absent: count a drop. Go to IDLE if tlast is set, otherwise DROP.
  - On a valid beat with tlast set: load H with the beat, set `sel`=data, count data, go to FLUSH.
  - On any other valid beat: load H with the beat, go to HOLD1.
- HOLD1 (beat 1 held, class not yet decided):
  - On a valid beat: decide `sel` from H and the beat, and count that class.
  - In the same edge: the selected output takes H, then H takes the beat.
  - Next state is FLUSH if tlast is set, otherwise FWD.
- FWD:
  - On a valid beat: the selected output takes H, then H takes the beat.
  - Next state is FLUSH on tlast.
- FLUSH:
  - The selected output takes H unconditionally; H holds the last beat.
  - The same edge also processes any valid input beat exactly as IDLE does, so packets may arrive back-to-back with no gap.
- DROP: discard beats until a beat with tlast set arrives, then go to IDLE.

Output rules:
- `tvalid` of the unselected stream is 0.
- Both `tvalid` outputs are 0 in any cycle with no emission.
- Counters increment at the decision edge, which is exactly once per packet.

Input gaps: tvalid may drop between beats. The state machine waits, and no output is produced until the next beat arrives.

## Timing
- Reset is asynchronous and immediate: state=IDLE, H=0, all output registers=0 (both `tvalid`=0, `tlast`=0), all counters=0.
- Reset mid-packet aborts that packet with no partial emission after reset. The first valid beat after reset is treated as a beat 1.
- Beat n of a multi-beat packet appears on the output in the cycle after beat n+1 is accepted.
- The last beat appears 2 cycles after it is accepted.
- A 1-beat packet appears 2 cycles after it is accepted.
- Output beats of a packet are contiguous only if the input beats were contiguous.
- Throughput: 1 beat per cycle, sustained across packet boundaries.

## Test plan
- 3-beat ctrl packet, beats contiguous at cycles 0–2 (TPID 8100, 0800, 0x45, proto 0x11, port bytes f1 f2): `c_m_axis_tvalid` high in cycles 2–4, `tlast` high in cycle 4, `m_axis_tvalid`=0 throughout, `ctrl_pkt_cnt`=1.
- 2-beat VLAN TCP packet, contiguous at cycles 0–1: `m_axis` emits in cycles 2–3, tdata/tuser/tkeep bit-exact, `data_pkt_cnt`=1.
- Packet without VLAN (`tdata[96+:16]`=16'h0008), 4 beats: no output on either stream, `drop_pkt_cnt`=1, next packet classified correctly.
- Back-to-back: 1-beat data packet at cycle 0, then a 2-beat ctrl packet at cycles 1–2: data beat in cycle 2 on `m_axis`, ctrl beats in cycles 3–4 on `c_m_axis`.
- Gapped input: beat 1 at cycle 0, beat 2 at cycle 5 (tlast): beat 1 out in cycle 6, beat 2 out in cycle 7.
- Reset asserted between beats 2 and 3 of a 4-beat packet: all outputs 0 immediately. After release, a fresh 2-beat data packet is forwarded with counters counting from 0.
